uart_rx: RTL and testbench
==========================

Name: uart_rx

Overview:
- Serial receiver; the receive-side counterpart of the counter-based baud/transmit path.
- Takes asynchronous RX line, oversamples it at OVERSAMPLE ticks per bit, recovers 8N1 frames (1 start, 8 data LSB-first, 1 stop).
- Presents each byte on a valid/ready interface to downstream logic in main.
- Default timing matches a bit period of 16 CLKIN cycles, i.e. the counter-bit-3 baud rate.

Parameters:
- TICK_DIV, 1, CLKIN cycles per oversample tick (>=1); internal prescaler, tick every TICK_DIV cycles.
- OVERSAMPLE, 16, ticks per bit period; even, >=4.

Ports:
- CLKIN  input  1  system clock, all logic on rising edge.
- RESETN  input  1  asynchronous, active-low reset.
- RX  input  1  serial line, idle high, asynchronous to CLKIN.
- DATA  output  8  received byte, stable while VALID high.
- VALID  output  1  byte available; held until accepted.
- READY  input  1  consumer accepts when VALID&READY at a rising edge.
- FRAME_ERR  output  1  one-cycle pulse: stop bit sampled low.
- OVERRUN  output  1  one-cycle pulse: byte completed while previous not accepted; new byte dropped.
- BUSY  output  1  high in any state other than IDLE.

Behaviour:
- Reset (async, RESETN=0):
  - FSM=IDLE; DATA=0x00; VALID=0; FRAME_ERR=0; OVERRUN=0; BUSY=0.
  - Both synchronizer flops=1, so no false start on release.
  - Prescaler and bit counters=0.
  - Reset mid-frame abandons the frame silently.
- Synchronizer: RX through 2 flops, giving rx_s. FSM uses only rx_s.
- Tick counter:
  - Prescaler runs only while FSM != IDLE; cleared on entry to START.
  - Phase counter counts ticks 0..OVERSAMPLE-1.
- IDLE: rx_s==0 -> START, clear counters.
- START: after OVERSAMPLE/2 ticks, sample rx_s.
  - 0 -> DATA, bit index=0, phase=0.
  - 1 -> IDLE (glitch rejected, no flags).
- DATA:
  - Every OVERSAMPLE ticks, sample rx_s into shift reg bit[index] (LSB first), then index++.
  - After the 8th sample -> STOP.
- STOP: after OVERSAMPLE ticks, sample rx_s.
  - 1 -> deliver byte, go IDLE.
  - 0 -> FRAME_ERR pulse, byte discarded, go BREAK.
- BREAK: wait until rx_s==1, then IDLE. No new start is detected while in BREAK.
- Delivery (at stop sample):
  - VALID==0: DATA<=shift reg; VALID<=1.
  - VALID==1 and READY==1 same edge: old byte consumed; DATA<=new byte; VALID stays 1.
  - VALID==1 and READY==0: OVERRUN pulse; DATA and VALID unchanged; new byte lost.
- Handshake: VALID&READY at an edge with no delivery -> VALID<=0 next cycle. READY while VALID=0 is ignored.
- Latency, TICK_DIV=1 and OVERSAMPLE=16:
  - Edge 0 = first edge sampling RX low.
  - FSM enters START after edge 2.
  - Start sample at edge 10; data bit k at edge 10+16(k+1); stop at edge 154.
  - VALID high after edge 154.
- FRAME_ERR and OVERRUN are registered, high exactly one cycle, and never asserted in the same cycle.

Test Plan:
1. Reset, then frame 0xA5 (16 clocks/bit), READY=1 -> VALID high after edge 154 for one cycle, DATA=0xA5; no FRAME_ERR or OVERRUN.
2. RX low for 4 clocks then high -> FSM returns to IDLE; no VALID, no FRAME_ERR; BUSY drops within 12 cycles; a following 0x5A frame is received correctly.
3. Frame 0xFF with stop bit low, line held low 40 more clocks -> one FRAME_ERR pulse, VALID stays 0; BUSY stays high until rx_s returns high; next 0x01 frame is received.
4. Back-to-back 0x3C then 0xC3, READY=0 -> DATA=0x3C with VALID held; OVERRUN pulses at the second stop sample; after READY=1 for one edge, VALID=0 and DATA=0x3C is not replaced.
5. READY asserted exactly at the second frame's stop edge -> no OVERRUN; DATA becomes 0xC3; VALID stays high.
6. RESETN low at data bit 4, released, then frame 0x81 -> all outputs 0 during reset; no stray VALID; 0x81 is received correctly.

Source files
------------

// File: rtl/uart_rx_if.sv
// uart_rx_if: byte delivery handshake plus status flags between the receiver and its consumer.
interface uart_rx_if;
    logic [7:0] DATA;
    logic       VALID;
    logic       READY;
    logic       FRAME_ERR;
    logic       OVERRUN;
    logic       BUSY;
    modport master(output DATA, VALID, FRAME_ERR, OVERRUN, BUSY, input READY);
    modport slave(input DATA, VALID, FRAME_ERR, OVERRUN, BUSY, output READY);
endinterface

// File: rtl/uart_rx.sv
// uart_rx: oversampling 8N1 receiver delivering bytes on a valid/ready interface.
module uart_rx #(
    parameter int TICK_DIV   = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic      CLKIN,
    input  logic      RESETN,
    input  logic      RX,
    uart_rx_if.master bus
);
    localparam int PW = TICK_DIV > 1 ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(OVERSAMPLE);
    typedef enum logic [2:0] {IDLE, START, BITS, STOP, BREAK} state_t;
    state_t        state, state_n;
    logic [1:0]    sync;
    logic          rx_s, tick, half, full;
    logic [PW-1:0] pre, pre_n;
    logic [CW-1:0] phase, phase_n;
    logic [2:0]    idx, idx_n;
    logic [7:0]    shift, shift_n, data, data_n;
    logic          valid, valid_n, ferr, ferr_n, ovr, ovr_n;
    assign rx_s = sync[1];
    assign tick = state != IDLE && pre == PW'(TICK_DIV - 1);
    assign half = tick && phase == CW'(OVERSAMPLE / 2 - 1);
    assign full = tick && phase == CW'(OVERSAMPLE - 1);
    always_ff @(posedge CLKIN or negedge RESETN) begin
        if (!RESETN) begin
            sync  <= 2'b11;
            state <= IDLE;
            pre   <= '0;
            phase <= '0;
            idx   <= '0;
            shift <= '0;
            data  <= '0;
            valid <= 1'b0;
            ferr  <= 1'b0;
            ovr   <= 1'b0;
        end else begin
            sync  <= {sync[0], RX};
            state <= state_n;
            pre   <= pre_n;
            phase <= phase_n;
            idx   <= idx_n;
            shift <= shift_n;
            data  <= data_n;
            valid <= valid_n;
            ferr  <= ferr_n;
            ovr   <= ovr_n;
        end
    end
    always_comb begin
        state_n = state;
        pre_n   = state == IDLE || tick ? '0 : pre + PW'(1);
        phase_n = state == IDLE ? '0 : !tick ? phase : full ? '0 : phase + CW'(1);
        idx_n   = idx;
        shift_n = shift;
        data_n  = data;
        valid_n = valid && !bus.READY;
        ferr_n  = 1'b0;
        ovr_n   = 1'b0;
        unique case (state)
            IDLE:  if (!rx_s) state_n = START;
            START: if (half) begin
                state_n = rx_s ? IDLE : BITS;
                phase_n = '0;
                idx_n   = '0;
            end
            BITS:  if (full) begin
                shift_n[idx] = rx_s;
                idx_n        = idx + 3'd1;
                if (idx == 3'd7) state_n = STOP;
            end
            STOP:  if (full) begin
                state_n = rx_s ? IDLE : BREAK;
                ferr_n  = !rx_s;
                // a byte arriving while the previous one is still held is dropped
                if (rx_s && (!valid || bus.READY)) begin
                    data_n  = shift;
                    valid_n = 1'b1;
                end else if (rx_s) ovr_n = 1'b1;
            end
            BREAK: if (rx_s) state_n = IDLE;
            default: state_n = IDLE;
        endcase
    end
    assign bus.DATA      = data;
    assign bus.VALID     = valid;
    assign bus.FRAME_ERR = ferr;
    assign bus.OVERRUN   = ovr;
    assign bus.BUSY      = state != IDLE;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: directed frames; stimulus queues expected bytes, a monitor pops them on each handshake.
module tb_uart_rx;
    logic clk = 1'b0, rst_n = 1'b0, rx = 1'b1;
    int cyc = 0, vectors = 0, errs = 0;
    int v_hi = 0, v_rise = -1, ferr_cnt = 0, ferr_cyc = -1, ovr_cnt = 0, ovr_cyc = -1;
    int tb, t0, n;
    logic v_prev = 1'b0, f_prev = 1'b0, o_prev = 1'b0;
    logic [7:0] exp_q[$];
    uart_rx_if bus();
    uart_rx dut(.CLKIN(clk), .RESETN(rst_n), .RX(rx), .bus(bus));
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;
    task automatic chk(input string name, input int act, input int req);
        vectors++;
        if (act != req) begin
            errs++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, req, cyc);
        end
    endtask
    // Monitor samples 2ns after the falling edge, once stimulus for the coming edge is settled.
    always @(negedge clk) begin
        #2;
        if (bus.VALID && bus.READY) begin
            if (exp_q.size() == 0) chk("unexpected_byte", {24'd0, bus.DATA}, 32'h100);
            else chk("data", {24'd0, bus.DATA}, {24'd0, exp_q.pop_front()});
        end
        if (bus.VALID) v_hi++;
        if (bus.VALID && !v_prev) v_rise = cyc;
        if (bus.FRAME_ERR) begin ferr_cnt++; ferr_cyc = cyc; end
        if (bus.OVERRUN) begin ovr_cnt++; ovr_cyc = cyc; end
        if (bus.FRAME_ERR && bus.OVERRUN) chk("ferr_and_ovr", 1, 0);
        if (bus.FRAME_ERR && f_prev) chk("ferr_width", 2, 1);
        if (bus.OVERRUN && o_prev) chk("ovr_width", 2, 1);
        v_prev = bus.VALID;
        f_prev = bus.FRAME_ERR;
        o_prev = bus.OVERRUN;
    end
    task automatic send(input logic [7:0] b, input logic stop);
        @(negedge clk);
        t0 = cyc;
        rx = 1'b0;
        repeat (15) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            rx = b[i];
            repeat (15) @(negedge clk);
        end
        @(negedge clk);
        rx = stop;
        repeat (15) @(negedge clk);
    endtask
    task automatic outs(input string name, input int req);
        chk(name, {20'd0, bus.DATA, bus.VALID, bus.FRAME_ERR, bus.OVERRUN, bus.BUSY}, req);
    endtask
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1);
    end
    initial begin
        int vh, fc, oc;
        bus.READY = 1'b0;
        repeat (3) @(negedge clk);
        outs("reset_outputs", 0);
        rst_n = 1'b1;
        repeat (4) @(negedge clk);
        outs("idle_after_reset", 0);
        // 1: basic frame with consumer ready
        bus.READY = 1'b1;
        exp_q.push_back(8'hA5);
        vh = v_hi;
        send(8'hA5, 1'b1);
        repeat (4) @(negedge clk);
        chk("t1_valid_latency", v_rise, t0 + 155);
        chk("t1_valid_cycles", v_hi - vh, 1);
        chk("t1_no_flags", ferr_cnt + ovr_cnt, 0);
        // 2: short glitch rejected
        vh = v_hi;
        @(negedge clk);
        rx = 1'b0;
        repeat (4) @(negedge clk);
        chk("t2_busy_on_glitch", bus.BUSY, 1);
        rx = 1'b1;
        n = 0;
        while (bus.BUSY && n < 20) begin @(negedge clk); n++; end
        chk("t2_busy_drop_in_12", n <= 12, 1);
        chk("t2_no_valid", v_hi - vh, 0);
        chk("t2_no_ferr", ferr_cnt, 0);
        exp_q.push_back(8'h5A);
        send(8'h5A, 1'b1);
        repeat (4) @(negedge clk);
        // 3: framing error, line held low (break)
        vh = v_hi;
        send(8'hFF, 1'b0);
        repeat (40) @(negedge clk);
        chk("t3_ferr_cycle", ferr_cyc, t0 + 155);
        chk("t3_ferr_count", ferr_cnt, 1);
        chk("t3_busy_in_break", bus.BUSY, 1);
        chk("t3_no_valid", v_hi - vh, 0);
        rx = 1'b1;
        repeat (4) @(negedge clk);
        chk("t3_busy_after_break", bus.BUSY, 0);
        exp_q.push_back(8'h01);
        send(8'h01, 1'b1);
        repeat (4) @(negedge clk);
        chk("t3_ferr_total", ferr_cnt, 1);
        // 4: overrun with consumer stalled
        bus.READY = 1'b0;
        exp_q.push_back(8'h3C);
        @(negedge clk);
        tb = cyc;
        send(8'h3C, 1'b1);
        send(8'hC3, 1'b1);
        repeat (4) @(negedge clk);
        chk("t4_ovr_cycle", ovr_cyc, tb + 161 + 155);
        chk("t4_ovr_count", ovr_cnt, 1);
        outs("t4_held_3c", {8'h3C, 4'b1000});
        bus.READY = 1'b1;
        @(negedge clk);
        bus.READY = 1'b0;
        @(negedge clk);
        outs("t4_consumed", {8'h3C, 4'b0000});
        // 5: consume exactly at the second stop sample
        exp_q.push_back(8'h3C);
        exp_q.push_back(8'hC3);
        oc = ovr_cnt;
        @(negedge clk);
        tb = cyc;
        fork
            begin send(8'h3C, 1'b1); send(8'hC3, 1'b1); end
            begin
                while (cyc < tb + 161 + 154) @(negedge clk);
                bus.READY = 1'b1;
                @(negedge clk);
                bus.READY = 1'b0;
            end
        join
        @(negedge clk);
        outs("t5_replaced_c3", {8'hC3, 4'b1000});
        chk("t5_no_ovr", ovr_cnt - oc, 0);
        bus.READY = 1'b1;
        @(negedge clk);
        bus.READY = 1'b0;
        // 6: reset mid-frame
        vh = v_hi;
        fc = ferr_cnt;
        @(negedge clk);
        tb = cyc;
        fork
            send(8'h55, 1'b1);
            begin
                while (cyc < tb + 1 + 16 * 5 + 8) @(negedge clk);
                rst_n = 1'b0;
                @(negedge clk);
                outs("t6_in_reset", 0);
            end
        join
        @(negedge clk);
        outs("t6_reset_end", 0);
        rst_n = 1'b1;
        bus.READY = 1'b1;
        exp_q.push_back(8'h81);
        send(8'h81, 1'b1);
        repeat (4) @(negedge clk);
        chk("t6_valid_once", v_hi - vh, 1);
        chk("t6_no_ferr", ferr_cnt - fc, 0);
        chk("queue_drained", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
        $finish;
    end
endmodule
